// File: rtl/usb_fifo_sc.sv
// usb_fifo_sc: single-clock USB endpoint FIFO with occupancy count, threshold flags, sticky errors and flush.
// Latency: dataOut valid 1 cycle after an accepted read; with USB_FIFO_FWFT_EN the head word is prefetched (first-word-fall-through).
// Backpressure: write refused when full unless a read is accepted on the same edge (sets overflow); read refused when empty (sets underflow).
module usb_fifo_sc #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_LEVEL   = 60,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] dataIn,
  input  logic                  fifoWEn,
  input  logic                  fifoREn,
  input  logic                  fifoClear,
  output logic [FIFO_WIDTH-1:0] dataOut,
  output logic                  dataOutValid,
  output logic [ADDR_WIDTH:0]   numElementsInFifo,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_acc, wr_acc, rd_rej, wr_rej;
`ifdef USB_FIFO_FWFT_EN
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  pf_load;
`endif

  always_comb begin
    // In prefetch mode empty tracks the output register, so the same accept rule holds for both builds.
    rd_acc = fifoREn & ~empty_q & ~fifoClear;
    rd_rej = fifoREn & empty_q;
    wr_acc = fifoWEn & ~fifoClear & (~full_q | rd_acc);
    wr_rej = fifoWEn & full_q & ~rd_acc;

    wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    dout_vld_d = 1'b0;

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end

`ifdef USB_FIFO_FWFT_EN
    ram_cnt    = count_q - {{ADDR_WIDTH{1'b0}}, dout_vld_q};
    pf_load    = ~fifoClear & (ram_cnt != '0) & (~dout_vld_q | rd_acc);
    dout_vld_d = dout_vld_q & ~rd_acc;
    if (pf_load) begin
      data_out_d = mem[rd_ptr_q];
      dout_vld_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end
`else
    if (rd_acc) begin
      data_out_d = mem[rd_ptr_q];
      dout_vld_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end
`endif

    ovf_d = ovf_q | wr_rej;
    udf_d = udf_q | rd_rej;

    if (fifoClear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      dout_vld_d = 1'b0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
`ifdef USB_FIFO_FWFT_EN
      data_out_d = '0;
`endif
    end

    full_d = (count_d == DEPTH_C);
    af_d   = (count_d >= AF_C);
    ae_d   = (count_d <= AE_C);
`ifdef USB_FIFO_FWFT_EN
    empty_d = ~dout_vld_d;
`else
    empty_d = (count_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      dout_vld_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      dout_vld_q <= dout_vld_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr_q] <= dataIn;
    end
  end

  assign dataOut           = data_out_q;
  assign dataOutValid      = dout_vld_q;
  assign numElementsInFifo = count_q;
  assign full              = full_q;
  assign empty             = empty_q;
  assign almostFull        = af_q;
  assign almostEmpty       = ae_q;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule

// File: tb/tb_usb_fifo_sc.sv
// Bench for usb_fifo_sc: queue-based reference model compared every cycle, plus literal spot checks.
module tb_usb_fifo_sc;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataIn;
  logic       fifoWEn, fifoREn, fifoClear;
  logic [7:0] dataOut;
  logic       dataOutValid;
  logic [6:0] numElementsInFifo;
  logic       full, empty, almostFull, almostEmpty, overflow, underflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  usb_fifo_sc dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .fifoWEn(fifoWEn), .fifoREn(fifoREn),
    .fifoClear(fifoClear), .dataOut(dataOut), .dataOutValid(dataOutValid),
    .numElementsInFifo(numElementsInFifo), .full(full), .empty(empty),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic step(input bit we, input bit re, input bit clr, input logic [7:0] d);
    fifoWEn = we; fifoREn = re; fifoClear = clr; dataIn = d;
    @(posedge clk);
    #1;
    fifoWEn = 1'b0; fifoREn = 1'b0; fifoClear = 1'b0;
  endtask

`ifndef USB_FIFO_FWFT_EN
  // Reference model: contents as a queue, outputs follow directly from the accept rules.
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_vld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  always @(posedge clk) begin
    bit rd_ok, wr_ok;
    if (rst) begin
      q.delete(); m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (fifoClear) begin
      q.delete(); m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rd_ok = fifoREn && (q.size() > 0);
      wr_ok = fifoWEn && ((q.size() < DEPTH) || rd_ok);
      m_vld = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(dataIn);
      if (fifoWEn && !wr_ok) m_ovf = 1'b1;
      if (fifoREn && !rd_ok) m_udf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_count", numElementsInFifo, q.size());
      chk("m_full", full, q.size() == DEPTH);
      chk("m_empty", empty, q.size() == 0);
      chk("m_afull", almostFull, q.size() >= 60);
      chk("m_aempty", almostEmpty, q.size() <= 4);
      chk("m_ovf", overflow, m_ovf);
      chk("m_udf", underflow, m_udf);
      chk("m_vld", dataOutValid, m_vld);
      chk("m_dout", dataOut, m_dout);
    end
  end
`endif

  initial begin
    rst = 1'b1; fifoWEn = 1'b0; fifoREn = 1'b0; fifoClear = 1'b0; dataIn = 8'h00;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", numElementsInFifo, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almostEmpty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almostFull, 0);
    chk("rst_flags", {overflow, underflow, dataOutValid}, 3'b000);
    chk("rst_dout", dataOut, 8'h00);
    rst = 1'b0;

`ifndef USB_FIFO_FWFT_EN
    // Fill, overflow, drain in order.
    for (int i = 0; i < 64; i++) step(1, 0, 0, 8'(i));
    chk("t1_full", full, 1);
    chk("t1_count", numElementsInFifo, 64);
    step(1, 0, 0, 8'hAA);
    chk("t1_ovf", overflow, 1);
    chk("t1_count_ovf", numElementsInFifo, 64);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 0, 8'h00);
      chk("t1_rd_vld", dataOutValid, 1);
      chk("t1_rd_dat", dataOut, 8'(i));
    end
    chk("t1_empty", empty, 1);
    step(0, 0, 0, 8'h00);
    chk("t1_vld_drop", dataOutValid, 0);
    chk("t1_hold", dataOut, 8'h3F);

    // Thresholds while filling, then full with simultaneous read/write.
    step(0, 0, 1, 8'h00);
    chk("t5_ovf_clr", overflow, 0);
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 0, 8'(8'h80 + i));
      if (i == 3)  chk("t5_ae_at4", almostEmpty, 1);
      if (i == 4)  chk("t5_ae_at5", almostEmpty, 0);
      if (i == 58) chk("t5_af_at59", almostFull, 0);
      if (i == 59) chk("t5_af_at60", almostFull, 1);
    end
    step(1, 1, 0, 8'h55);
    chk("t3_count", numElementsInFifo, 64);
    chk("t3_head", dataOut, 8'h80);
    chk("t3_no_ovf", overflow, 0);
    for (int i = 0; i < 64; i++) step(0, 1, 0, 8'h00);
    chk("t3_last", dataOut, 8'h55);
    chk("t3_empty", empty, 1);

    // Empty with simultaneous read/write.
    step(1, 1, 0, 8'h12);
    chk("t4_udf", underflow, 1);
    chk("t4_count", numElementsInFifo, 1);
    chk("t4_vld", dataOutValid, 0);
    step(0, 1, 0, 8'h00);
    chk("t4_dat", dataOut, 8'h12);

    // Steady occupancy across pointer wrap.
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'(8'h20 + i));
    for (int k = 0; k < 100; k++) begin
      step(1, 1, 0, 8'(8'h2A + k));
      chk("t2_dat", dataOut, 8'(8'h20 + k));
      chk("t2_count", numElementsInFifo, 10);
    end

    // Flush beats a same-edge write; dataOut is retained.
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 64; i++) step(1, 0, 0, 8'(i));
    step(1, 0, 0, 8'hAA);
    for (int i = 0; i < 34; i++) step(0, 1, 0, 8'h00);
    chk("t6_count30", numElementsInFifo, 30);
    chk("t6_ovf_set", overflow, 1);
    step(1, 0, 1, 8'h77);
    chk("t6_count", numElementsInFifo, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ovf", overflow, 0);
    chk("t6_dout_kept", dataOut, 8'h21);
    step(0, 1, 0, 8'h00);
    chk("t6_wr_ignored", underflow, 1);
    chk("t6_dout_hold", dataOut, 8'h21);

    // Reset mid-stream discards data.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(i + 1));
    rst = 1'b1;
    step(0, 0, 0, 8'h00);
    rst = 1'b0;
    chk("rst2_count", numElementsInFifo, 0);
    chk("rst2_dout", dataOut, 8'h00);
    step(1, 0, 0, 8'hC3);
    step(0, 1, 0, 8'h00);
    chk("rst2_first", dataOut, 8'hC3);
`else
    step(1, 0, 0, 8'h5A);
    chk("fw_vld_p1", dataOutValid, 0);
    chk("fw_cnt_p1", numElementsInFifo, 1);
    step(0, 0, 0, 8'h00);
    chk("fw_vld_p2", dataOutValid, 1);
    chk("fw_dat_p2", dataOut, 8'h5A);
    chk("fw_empty_p2", empty, 0);
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    chk("fw_cnt3", numElementsInFifo, 3);
    chk("fw_head", dataOut, 8'h5A);
    step(0, 1, 0, 8'h00);
    chk("fw_rd1", dataOut, 8'h01);
    chk("fw_rd1_vld", dataOutValid, 1);
    step(0, 1, 0, 8'h00);
    chk("fw_rd2", dataOut, 8'h02);
    chk("fw_cnt1", numElementsInFifo, 1);
    step(0, 1, 0, 8'h00);
    chk("fw_drained", {empty, dataOutValid}, 2'b10);
    chk("fw_cnt0", numElementsInFifo, 0);
    step(0, 1, 0, 8'h00);
    chk("fw_udf", underflow, 1);
    step(1, 0, 0, 8'h33);
    step(0, 0, 0, 8'h00);
    chk("fw_dat33", dataOut, 8'h33);
    step(0, 0, 1, 8'h00);
    chk("fw_clr_vld", dataOutValid, 0);
    chk("fw_clr_dout", dataOut, 8'h00);
    chk("fw_clr_udf", underflow, 0);
    chk("fw_clr_cnt", numElementsInFifo, 0);
`endif

    cmp_en = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_fifo_sc.md
Name: usb_fifo_sc

Overview:
- Single-clock, parametrised FIFO for USB endpoint buffering.
- Wraps a dual-port RAM with synchronous read, plus pointer, count and flag logic.
- Adds the following, none of which the plain RAM has: occupancy count, full/empty and programmable almost-thresholds, sticky overflow/underflow error flags, synchronous flush.
- Sits between the USB SIE byte stream and the bus-side endpoint registers.

Parameters:
- FIFO_WIDTH, 8, data word width in bits.
- FIFO_DEPTH, 64, number of words; must be a power of two and at least 4.
- ADDR_WIDTH, 6, log2(FIFO_DEPTH); pointer and address width.
- AF_LEVEL, 60, almostFull asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almostEmpty asserts when count <= AE_LEVEL.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- dataIn, input, FIFO_WIDTH, write data.
- fifoWEn, input, 1, write request.
- fifoREn, input, 1, read request.
- fifoClear, input, 1, synchronous flush.
- dataOut, output, FIFO_WIDTH, read data.
- dataOutValid, output, 1, dataOut holds a newly read word.
- numElementsInFifo, output, ADDR_WIDTH+1, occupancy, range 0..FIFO_DEPTH.
- full, output, 1, count == FIFO_DEPTH.
- empty, output, 1, count == 0.
- almostFull, output, 1, count >= AF_LEVEL.
- almostEmpty, output, 1, count <= AE_LEVEL.
- overflow, output, 1, sticky: a write was rejected.
- underflow, output, 1, sticky: a read was rejected.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - wrPtr = rdPtr = 0, count = 0.
  - dataOut = 0, dataOutValid = 0.
  - empty = 1, almostEmpty = 1, full = 0, almostFull = 0.
  - overflow = 0, underflow = 0.
  - RAM contents are not cleared.
- Reset mid-stream discards all data; the first write after reset lands at address 0.
- Accept rules, evaluated on pre-edge state:
  - rdAcc = fifoREn & !empty.
  - wrAcc = fifoWEn & (!full | rdAcc).
- Accepted write: RAM[wrPtr] <= dataIn; wrPtr increments modulo FIFO_DEPTH (natural wrap of ADDR_WIDTH bits).
- Accepted read: dataOut <= RAM[rdPtr], valid one cycle after the request; rdPtr increments modulo FIFO_DEPTH.
- dataOutValid is 1 in the cycle after an accepted read and 0 otherwise. dataOut holds its value between reads.
- Count update:
  - +1 on wrAcc only.
  - -1 on rdAcc only.
  - Unchanged when both are accepted.
- Full with simultaneous read and write: both are accepted, count stays FIFO_DEPTH, and dataOut returns the old head word, never the incoming one.
- Empty with simultaneous read and write: the write is accepted, the read is rejected and sets underflow, count becomes 1.
- Rejected write (fifoWEn & full & !rdAcc): data is dropped, overflow <= 1.
- Rejected read (fifoREn & empty): underflow <= 1; dataOut is unchanged and dataOutValid stays 0.
- overflow and underflow are sticky; only rst or fifoClear clears them.
- All flags are registered and derived from the post-edge count, so they are valid in the same cycle as numElementsInFifo.
- fifoClear has priority over fifoWEn and fifoREn in the same cycle. It produces the reset state except that dataOut retains its value.

Optional Feature:
- Macro: USB_FIFO_FWFT_EN.
- Undefined: standard mode as described above, with 1-cycle read latency.
- Defined: first-word-fall-through mode.
  - An output register is prefetched from RAM whenever it is empty and the RAM holds data.
  - dataOutValid = 1 whenever dataOut holds the head word.
  - fifoREn with dataOutValid=1 consumes that word; the next word appears in the following cycle with no bubble while data remains.
  - A write into a completely empty FIFO gives dataOutValid=1 two cycles after the write edge.
  - numElementsInFifo and full include the prefetched word.
  - empty = !dataOutValid.
  - A read while dataOutValid=0 sets underflow.
  - fifoClear and rst also clear the prefetch register and dataOutValid.

Test Plan:
1. Depth 64, 8-bit: write 0x00..0x3F, then one more write of 0xAA -> full=1, count=64, overflow=1; read 64 words -> 0x00..0x3F in order, each valid one cycle after its request, empty=1 at the end.
2. Wrap-around: write and read 100 words one-for-one with an offset of 10 words -> data order preserved across the pointer wrap, count steady at 10.
3. Full plus simultaneous read and write of 0x55 -> count stays 64, dataOut returns the old head; 0x55 is read last after draining.
4. Empty plus simultaneous fifoREn and fifoWEn of 0x12 -> underflow=1, count=1; next read returns 0x12.
5. Thresholds with AF_LEVEL=60, AE_LEVEL=4: fill to 4 -> almostEmpty=1; fill to 5 -> almostEmpty=0; fill to 60 -> almostFull=1.
6. Assert fifoClear with count=30 and overflow=1, with a write on the same edge -> count=0, empty=1, overflow=0, write ignored. In FWFT build: a single write gives dataOutValid at +2 cycles with dataOut equal to that word.
